// File: rtl/pc_unit_if.sv
// Fetch-stage program-counter bus: control inputs from decode/hazard logic and the
// fetch address outputs returned by pc_unit.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_addr;
  logic             exc_valid;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc_result;
  logic             pc_valid;
  logic [WIDTH-1:0] pc_plus_inc_c;
  logic             redirect_pending;
  logic             ras_empty;

  modport master (
    output stall, redirect_valid, redirect_addr, exc_valid, call, ret,
    input  pc_result, pc_valid, pc_plus_inc_c, redirect_pending, ras_empty
  );

  modport slave (
    input  stall, redirect_valid, redirect_addr, exc_valid, call, ret,
    output pc_result, pc_valid, pc_plus_inc_c, redirect_pending, ras_empty
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with exception/redirect priority and a stall-safe deferred redirect.
// Optional return-address stack is built when PC_RAS_EN is defined.
module pc_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int unsigned      INC        = 4,
  parameter logic [31:0]      EXC_VECTOR = 32'h0000_0180,
  parameter int unsigned      RAS_DEPTH  = 4
) (
  input logic       i_clk,
  input logic       i_rst_n,
  pc_unit_if.slave  io_pc
);

  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(INC - 1);
  localparam logic [WIDTH-1:0] EXC_ADDR   = WIDTH'(EXC_VECTOR);

  // S_OFF: first edge after reset, fetch address not yet valid
  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic             r_pc_valid;
  logic             r_pending;
  logic [WIDTH-1:0] r_pend_addr;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pend_nxt;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_redir_aligned;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_call;
  logic             w_ras_hit;
  logic             w_push;
  logic             w_pop;

  assign w_pc_inc        = r_pc + INC_W;
  assign w_redir_aligned = io_pc.redirect_addr & ALIGN_MASK;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: tracks valid/pending-redirect status
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OFF: w_state_nxt = S_RUN;
      S_RUN, S_PEND: begin
        if (io_pc.exc_valid) begin
          w_state_nxt = S_RUN;
        end else if (io_pc.redirect_valid && !io_pc.stall) begin
          w_state_nxt = S_RUN;
        end else if (io_pc.redirect_valid) begin
          w_state_nxt = S_PEND;
        end else if (io_pc.stall) begin
          w_state_nxt = r_state;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

  // Output/datapath: next PC, pending address and stack operations
  always_comb begin
    w_pc_nxt   = r_pc;
    w_pend_nxt = r_pend_addr;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    if (r_state == S_RUN || r_state == S_PEND) begin
      if (io_pc.exc_valid) begin
        w_pc_nxt = EXC_ADDR;
      end else if (io_pc.redirect_valid && !io_pc.stall) begin
        w_pc_nxt = w_redir_aligned;
      end else if (io_pc.redirect_valid) begin
        w_pend_nxt = w_redir_aligned;
      end else if (io_pc.stall) begin
        w_pc_nxt = r_pc;
      end else if (r_state == S_PEND) begin
        w_pc_nxt = r_pend_addr & ALIGN_MASK;
        w_push   = w_call;
      end else if (w_ras_hit) begin
        w_pc_nxt = w_ras_top;
        w_pop    = 1'b1;
        w_push   = w_call;
      end else begin
        w_pc_nxt = w_pc_inc;
        w_push   = w_call;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc        <= RESET_ADDR;
      r_pc_valid  <= 1'b0;
      r_pending   <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_pc_valid  <= (w_state_nxt != S_OFF);
      r_pending   <= (w_state_nxt == S_PEND);
      r_pend_addr <= w_pend_nxt;
    end
  end

  assign io_pc.pc_result        = r_pc;
  assign io_pc.pc_valid         = r_pc_valid;
  assign io_pc.pc_plus_inc_c    = w_pc_inc;
  assign io_pc.redirect_pending = r_pending;

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] r_ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_ras_wptr;
  logic [CNT_W-1:0] r_ras_cnt;
  logic             r_ras_empty;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_next_idx;
  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_wptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_call    = io_pc.call;
  assign w_ras_hit = io_pc.ret && !r_ras_empty;

  // Circular stack: wptr is the next free slot, the entry below it is the top
  assign w_top_idx  = (r_ras_wptr == '0) ? PTR_W'(RAS_DEPTH - 1) : r_ras_wptr - PTR_W'(1);
  assign w_next_idx = (r_ras_wptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_ras_wptr + PTR_W'(1);
  assign w_ras_top  = r_ras_mem[w_top_idx];

  always_comb begin
    w_wptr_nxt = r_ras_wptr;
    w_cnt_nxt  = r_ras_cnt;
    w_wr_idx   = r_ras_wptr;
    if (w_push && w_pop) begin
      w_wr_idx = w_top_idx;
    end else if (w_push) begin
      w_wptr_nxt = w_next_idx;
      if (r_ras_cnt != CNT_W'(RAS_DEPTH)) begin
        w_cnt_nxt = r_ras_cnt + CNT_W'(1);
      end
    end else if (w_pop) begin
      w_wptr_nxt = w_top_idx;
      w_cnt_nxt  = r_ras_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ras_wptr  <= '0;
      r_ras_cnt   <= '0;
      r_ras_empty <= 1'b1;
    end else begin
      r_ras_wptr  <= w_wptr_nxt;
      r_ras_cnt   <= w_cnt_nxt;
      r_ras_empty <= (w_cnt_nxt == '0);
    end
  end

  // Stack storage needs no reset: the count gates every read
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_ras_mem[w_wr_idx] <= w_pc_inc;
    end
  end

  assign io_pc.ras_empty = r_ras_empty;
`else
  logic w_unused_ras;

  assign w_call          = 1'b0;
  assign w_ras_hit       = 1'b0;
  assign w_ras_top       = '0;
  assign w_unused_ras    = &{1'b0, io_pc.call, io_pc.ret, w_push, w_pop};
  assign io_pc.ras_empty = 1'b1;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a reference model pushes expected state to a scoreboard
// queue as each step is driven; results are popped and checked after the edge.
module tb_pc_unit;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        pend;
    logic        empty;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst8_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t sb[$];

  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_pend;
  logic [31:0] m_pend_addr;
  logic [31:0] m_ras[$];

  localparam int unsigned DEPTH = 2;

  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(32)) pif ();
  pc_unit_if #(.WIDTH(8))  pif8 ();

  pc_unit #(.WIDTH(32), .RESET_ADDR(32'h0), .INC(4), .EXC_VECTOR(32'h180), .RAS_DEPTH(DEPTH)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_pc   (pif)
  );

  pc_unit #(.WIDTH(8), .RESET_ADDR(8'hF8), .INC(4), .EXC_VECTOR(32'h180), .RAS_DEPTH(DEPTH)) u_dut8 (
    .i_clk   (clk),
    .i_rst_n (rst8_n),
    .io_pc   (pif8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_empty();
`ifdef PC_RAS_EN
    return (m_ras.size() == 0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_push(input logic [31:0] v);
`ifdef PC_RAS_EN
    if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
    m_ras.push_back(v);
`else
    if (v == 32'hDEAD_BEEF) m_pend_addr = m_pend_addr;
`endif
  endfunction

  function automatic void model_reset();
    m_pc = 32'h0;
    m_valid = 1'b0;
    m_pend = 1'b0;
    m_pend_addr = 32'h0;
    m_ras.delete();
  endfunction

  // Called at a falling edge: drive, model, then check just after the rising edge
  task automatic step(input logic st, input logic rv, input logic [31:0] ra,
                      input logic ex, input logic ca, input logic re);
    logic [31:0] pinc;
    exp_t e;
    exp_t got;
    pif.stall = st;
    pif.redirect_valid = rv;
    pif.redirect_addr = ra;
    pif.exc_valid = ex;
    pif.call = ca;
    pif.ret = re;
    pinc = m_pc + 32'd4;
    if (!m_valid) begin
      m_valid = 1'b1;
    end else if (ex) begin
      m_pc = 32'h180;
      m_pend = 1'b0;
    end else if (rv && !st) begin
      m_pc = ra & ~32'd3;
      m_pend = 1'b0;
    end else if (rv) begin
      m_pend_addr = ra & ~32'd3;
      m_pend = 1'b1;
    end else if (!st) begin
      if (m_pend) begin
        m_pc = m_pend_addr;
        m_pend = 1'b0;
        if (ca) model_push(pinc);
`ifdef PC_RAS_EN
      end else if (re && m_ras.size() != 0) begin
        m_pc = m_ras.pop_back();
        if (ca) model_push(pinc);
`endif
      end else begin
        m_pc = pinc;
        if (ca) model_push(pinc);
      end
    end
    e.pc = m_pc;
    e.valid = m_valid;
    e.pend = m_pend;
    e.empty = model_empty();
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("pc", pif.pc_result, got.pc);
    chk("valid", 32'(pif.pc_valid), 32'(got.valid));
    chk("pending", 32'(pif.redirect_pending), 32'(got.pend));
    chk("plus_inc", pif.pc_plus_inc_c, got.pc + 32'd4);
    chk("ras_empty", 32'(pif.ras_empty), 32'(got.empty));
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    pif.stall = 1'b0;
    pif.redirect_valid = 1'b0;
    pif.redirect_addr = 32'h0;
    pif.exc_valid = 1'b0;
    pif.call = 1'b0;
    pif.ret = 1'b0;
    pif8.stall = 1'b0;
    pif8.redirect_valid = 1'b0;
    pif8.redirect_addr = 8'h0;
    pif8.exc_valid = 1'b0;
    pif8.call = 1'b0;
    pif8.ret = 1'b0;
    model_reset();

    @(negedge clk);
    chk("rst_pc", pif.pc_result, 32'h0);
    chk("rst_valid", 32'(pif.pc_valid), 32'h0);
    chk("rst_pending", 32'(pif.redirect_pending), 32'h0);
    chk("rst_ras_empty", 32'(pif.ras_empty), 32'h1);
    rst_n = 1'b1;

    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("release_pc", pif.pc_result, 32'h0);
    repeat (4) idle();
    chk("seq_pc", pif.pc_result, 32'h10);

    // Alignment of a misaligned target
    step(1'b0, 1'b1, 32'h103, 1'b0, 1'b0, 1'b0);
    chk("align_pc", pif.pc_result, 32'h100);
    idle();

    // Deferred redirect with overwrite while stalled
    step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    chk("stall_hold_pc", pif.pc_result, 32'h20);
    step(1'b1, 1'b1, 32'h83, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("deferred_pc", pif.pc_result, 32'h80);
    idle();

    // Exception beats redirect and stall
    step(1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0);
    chk("exc_pc", pif.pc_result, 32'h180);
    idle();
    step(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("exc_clears_pend", pif.pc_result, 32'h184);

    // Wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    idle();
    chk("wrap32_pc", pif.pc_result, 32'h0);

    // Return-address stack sequence (Call/Ret are ignored without the stack)
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset with a pending redirect and a non-empty stack
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_pc", pif.pc_result, 32'h0);
    chk("async_rst_valid", 32'(pif.pc_valid), 32'h0);
    chk("async_rst_pending", 32'(pif.redirect_pending), 32'h0);
    chk("async_rst_ras_empty", 32'(pif.ras_empty), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    chk("post_rst_pc", pif.pc_result, 32'h8);

    // 8-bit instance wraps 0xFC -> 0x00
    rst8_n = 1'b1;
    @(posedge clk);
    #1;
    chk("w8_valid", 32'(pif8.pc_valid), 32'h1);
    chk("w8_first_pc", 32'(pif8.pc_result), 32'hF8);
    @(posedge clk);
    #1;
    chk("w8_pc_fc", 32'(pif8.pc_result), 32'hFC);
    chk("w8_plus_inc_wrap", 32'(pif8.pc_plus_inc_c), 32'h00);
    @(posedge clk);
    #1;
    chk("w8_wrap_pc", 32'(pif8.pc_result), 32'h00);
    @(posedge clk);
    #1;
    chk("w8_after_wrap", 32'(pif8.pc_result), 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the fetch stage.
- Holds the PC and computes the next fetch address each cycle.
- Priority sources, highest first: exception vector, branch/jump redirect, redirect deferred during a stall, optional return-address stack, sequential increment.
- Adds a stall-safe pending-redirect buffer, so a redirect raised while fetch is frozen is never lost.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_ADDR, 0, PC value loaded by reset.
- INC, 4, sequential increment in bytes; power of two, at least 1.
- EXC_VECTOR, 32'h00000180, exception handler address (truncated to WIDTH).
- RAS_DEPTH, 4, return-address stack entries (only used with PC_RAS_EN), at least 2.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Stall  input  1  freeze PC (hazard unit).
- RedirectValid  input  1  branch/jump taken this cycle.
- RedirectAddr  input  WIDTH  branch/jump target.
- ExcValid  input  1  exception; jump to EXC_VECTOR.
- Call  input  1  current instruction is a call (RAS push).
- Ret  input  1  current instruction is a return (RAS pop).
- PCResult  output  WIDTH  current fetch address (registered).
- PCValid  output  1  PCResult is a valid fetch address.
- PCPlusInc  output  WIDTH  PCResult+INC, combinational, mod 2^WIDTH.
- RedirectPending  output  1  deferred redirect is held.
- RASEmpty  output  1  stack holds no entries.

Behaviour:
- Reset low, asynchronous regardless of Clk:
  - PCResult=RESET_ADDR, PCValid=0, RedirectPending=0.
  - Pending address=0, RAS count=0 (RASEmpty=1).
- Reset release:
  - First rising edge with Reset high sets PCValid=1; PCResult stays RESET_ADDR. All other inputs are ignored on that edge.
  - PCValid then stays 1 until the next reset.
- Edges with PCValid=1, first matching rule wins:
  1. ExcValid=1: PCResult<=EXC_VECTOR; pending cleared; Stall, redirect and RAS ops are ignored.
  2. RedirectValid=1, Stall=0: PCResult<=RedirectAddr; pending cleared.
  3. RedirectValid=1, Stall=1: PCResult holds; pending address<=RedirectAddr; RedirectPending<=1. A newer redirect overwrites an older pending one.
  4. Stall=1: PCResult holds; pending unchanged; no RAS push or pop.
  5. RedirectPending=1: PCResult<=pending address; RedirectPending<=0.
  6. Ret=1 with RASEmpty=0 (PC_RAS_EN only): PCResult<=top of stack; pop.
  7. Otherwise: PCResult<=PCResult+INC, wrapping modulo 2^WIDTH (all-ones region wraps to 0).
- Alignment: the low log2(INC) bits of RedirectAddr and of the pending address are forced to 0 before loading.
- Latency:
  - Redirect/exception: 1 cycle, target visible the cycle after assertion.
  - Deferred redirect: appears on the first edge with Stall=0.
- Call/Ret are sampled only on edges where rule 5, 6 or 7 applies; they are ignored under rules 1-4.
- RAS push:
  - Call=1 pushes the current PCPlusInc.
  - Stack full: the oldest entry is overwritten (circular) and the count saturates at RAS_DEPTH.
- RAS pop:
  - Ret=1 with RASEmpty=1 means no pop; PC takes rule 7.
  - Call=1 and Ret=1 together: pop supplies the target (rule 6), then PCPlusInc of the current PC is pushed into the freed slot; count unchanged.
- Reset asserted mid-operation aborts everything immediately; pending and stack contents are discarded.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined:
  - RAS_DEPTH-entry return-address stack is built; rule 6 and the push/pop behaviour apply.
  - RASEmpty reflects count==0.
- Undefined:
  - No stack storage; Call and Ret are ignored; rule 6 never fires.
  - RASEmpty is tied to 1.
  - All other behaviour is identical.

Test Plan:
- Reset low mid-run -> PCResult=0x0, PCValid=0 immediately. Release -> PCValid=1 next edge, then 0x0,0x4,0x8 on successive edges.
- At PC=0x10, RedirectValid=1, RedirectAddr=0x103 -> PCResult=0x100 next cycle (alignment), then 0x104.
- Stall=1 at PC=0x20 with RedirectValid=1, RedirectAddr=0x40:
  - PC holds 0x20 and RedirectPending=1.
  - A second redirect to 0x80 while still stalled overwrites the pending address.
  - On Stall=0 -> PCResult=0x80, RedirectPending=0.
- ExcValid=1 together with RedirectValid=1 and Stall=1 at PC=0x30 -> PCResult=0x180, RedirectPending=0.
- WIDTH=8, INC=4, PC=0xFC -> next PC=0x00.
- PC_RAS_EN, RAS_DEPTH=2:
  - Call at 0x10, 0x20, 0x30 -> oldest entry (0x14) overwritten.
  - Ret, Ret -> PC 0x34 then 0x24; RASEmpty=1.
  - Third Ret -> PC 0x28 (sequential).
